ysyx_25040129_trap_seq: RTL
===========================

Name: ysyx_25040129_trap_seq

Overview:
- Trap/return sequencer that sits directly upstream of the machine-mode CSR register file and is the sole driver of its read/write port.
- Accepts ECALL/exception and MRET requests from the execute stage and issues a multi-cycle sequence of single-port CSR read-modify-writes (MEPC, MCAUSE, MSTATUS).
- Then emits a one-cycle PC redirect to the fetch stage.
- When idle, forwards the execute stage's CSR-instruction accesses unchanged.

Parameters:
- VEC_EN, 0, 1 enables vectored mode: when mtvec[1:0]==2'b01 and cause[31]==1, target = base + 4*cause[30:0].
- XLEN, 32, data width; fixed at 32, present for width checks only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  trap/return request.
- req_is_mret  in  1  1 = MRET, 0 = trap.
- req_pc  in  32  PC of the faulting/ECALL instruction.
- req_cause  in  32  mcause value; ECALL = 32'd11.
- req_ready  out  1  high only in IDLE.
- inst_csr_write  in  1  CSR-instruction write enable from execute.
- inst_csr_raddr  in  CSR_DIG  CSR-instruction read address.
- inst_csr_waddr  in  CSR_DIG  CSR-instruction write address.
- inst_csr_wdata  in  32  CSR-instruction write data.
- inst_csr_rdata  out  32  read data returned to execute (csr_rdata passthrough).
- inst_stall  out  1  high while not IDLE.
- csr_write  out  1  to CSR file.
- csr_read_addr  out  CSR_DIG  to CSR file.
- csr_write_addr  out  CSR_DIG  to CSR file.
- csr_data  out  32  to CSR file.
- csr_rdata  in  32  combinational read data from CSR file.
- redirect_valid  out  1  one-cycle pulse.
- redirect_pc  out  32  new fetch PC, 4-byte aligned.

Behaviour:
- Reset (rst low, asynchronous):
  - State to IDLE; latched pc/cause cleared.
  - Outputs: req_ready=1 once in IDLE, all other outputs 0.
  - Reset mid-sequence abandons it: no further CSR writes, no redirect.
- States: IDLE, T_EPC, T_CAUSE, T_STAT, T_VEC, R_STAT, R_EPC.
- IDLE:
  - csr_* outputs mirror the inst_csr_* inputs combinationally; inst_stall=0.
  - On req_valid (ready=1), latch req_pc & ~3 and req_cause.
  - Next state: R_STAT if req_is_mret, else T_EPC.
  - An inst_csr_write in the same cycle as the handshake is still performed that cycle, before the sequence.
- Non-IDLE states:
  - inst_stall=1; inst_csr_write is ignored; req_ready=0.
  - inst_csr_rdata still reflects csr_rdata.
- T_EPC: write MEPC = latched pc. Next: T_CAUSE.
- T_CAUSE: write MCAUSE = latched cause. Next: T_STAT.
- T_STAT: read MSTATUS and write it back modified in the same cycle:
  - MPIE(bit7) <= MIE(bit3).
  - MIE <= 0.
  - MPP(12:11) <= 2'b11.
  - All other bits unchanged.
  - Next: T_VEC.
- T_VEC: read MTVEC; no write.
  - base = {mtvec[31:2], 2'b00}.
  - redirect_pc = base, or base + (cause[29:0]<<2) under the VEC_EN rule.
  - redirect_valid=1. Next: IDLE.
- R_STAT: read MSTATUS, write modified:
  - MIE <= MPIE.
  - MPIE <= 1.
  - MPP <= 2'b11 (M-only core).
  - Next: R_EPC.
- R_EPC: read MEPC; redirect_pc = {mepc[31:2], 2'b00}; redirect_valid=1. Next: IDLE.
- Latency from handshake cycle (cycle 0):
  - Trap: writes in cycles 1–3, redirect in cycle 4.
  - MRET: write in cycle 1, redirect in cycle 2.
  - A new request is accepted in the cycle after redirect at the earliest.
- csr_write is exactly 1 in the T_EPC, T_CAUSE, T_STAT and R_STAT states, and is 0 in T_VEC/R_EPC.
- Addition in T_VEC wraps modulo 2^32.
- req_valid deasserted mid-sequence has no effect; request inputs are sampled only at the handshake.

Decomposition:
- Shared defines/package holds:
  - CSR_DIG and the CSR address constants (MSTATUS, MTVEC, MEPC, MCAUSE).
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11).
  - State encoding.
- One combinational sub-module, ysyx_25040129_mstatus_upd: inputs old mstatus and is_mret; output new mstatus.

Test Plan:
- Trap: mstatus=32'h8, mtvec=32'h8000_0100, req pc=32'h8000_0040, cause=11.
  - Expected: MEPC=32'h8000_0040 (cycle 1), MCAUSE=11 (cycle 2), mstatus=32'h1880 (cycle 3).
  - Expected: redirect_pc=32'h8000_0100 (cycle 4).
- MRET: mstatus=32'h1880, mepc=32'h8000_0044.
  - Expected: mstatus=32'h1888 (cycle 1), then redirect_pc=32'h8000_0044 (cycle 2).
- Passthrough/stall: inst_csr_write to MTVEC with 32'h8000_0200 in IDLE → written same cycle.
  - Same write during T_CAUSE → inst_stall=1, MTVEC unchanged.
- Misaligned inputs: req_pc=32'h8000_0043 → MEPC=32'h8000_0040; mtvec=32'h8000_0103 with VEC_EN=0 → redirect_pc=32'h8000_0100.
- VEC_EN=1, mtvec=32'h8000_0101, cause=32'h8000_0007 → redirect_pc=32'h8000_011C.
- Reset low during T_STAT → mstatus not written, no redirect; req_ready=1 after rst released.

Source files
------------

// File: rtl/ysyx_25040129_trap_seq_pkg.sv
// Shared CSR addresses, mstatus field positions and sequencer state encoding
// for the trap/return sequencer.
package ysyx_25040129_trap_seq_pkg;
    localparam int CSR_DIG = 12;
    typedef logic [CSR_DIG-1:0] csr_addr_t;

    localparam csr_addr_t CSR_MSTATUS = 12'h300;
    localparam csr_addr_t CSR_MTVEC   = 12'h305;
    localparam csr_addr_t CSR_MEPC    = 12'h341;
    localparam csr_addr_t CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [2:0] {
        S_IDLE, S_T_EPC, S_T_CAUSE, S_T_STAT, S_T_VEC, S_R_STAT, S_R_EPC
    } state_e;
endpackage

// File: rtl/ysyx_25040129_trap_seq_if.sv
// Single read/write port of the machine-mode CSR file; the sequencer is the
// master, the CSR file the slave (read data is combinational).
interface ysyx_25040129_trap_seq_if #(parameter int XLEN = 32);
    import ysyx_25040129_trap_seq_pkg::*;

    logic            csr_write;
    csr_addr_t       csr_read_addr;
    csr_addr_t       csr_write_addr;
    logic [XLEN-1:0] csr_data;
    logic [XLEN-1:0] csr_rdata;

    modport master (output csr_write, csr_read_addr, csr_write_addr, csr_data,
                    input  csr_rdata);
    modport slave  (input  csr_write, csr_read_addr, csr_write_addr, csr_data,
                    output csr_rdata);
endinterface

// File: rtl/ysyx_25040129_mstatus_upd.sv
// Combinational mstatus rewrite for trap entry (stack MIE into MPIE) and
// MRET (pop MPIE into MIE). MPP is pinned to machine mode either way.
module ysyx_25040129_mstatus_upd
    import ysyx_25040129_trap_seq_pkg::*;
(
    input  logic [31:0] old_mstatus,
    input  logic        is_mret,
    output logic [31:0] new_mstatus
);
    always_comb begin
        new_mstatus = old_mstatus;
        new_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        if (is_mret) begin
            new_mstatus[MSTATUS_MIE]  = old_mstatus[MSTATUS_MPIE];
            new_mstatus[MSTATUS_MPIE] = 1'b1;
        end else begin
            new_mstatus[MSTATUS_MPIE] = old_mstatus[MSTATUS_MIE];
            new_mstatus[MSTATUS_MIE]  = 1'b0;
        end
    end
endmodule

// File: rtl/ysyx_25040129_trap_seq.sv
// Trap/MRET sequencer: owns the CSR file port, runs the MEPC/MCAUSE/MSTATUS
// read-modify-write sequence, then pulses a fetch redirect.
module ysyx_25040129_trap_seq
    import ysyx_25040129_trap_seq_pkg::*;
#(
    parameter bit VEC_EN = 1'b0,
    parameter int XLEN   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            req_is_mret,
    input  logic [XLEN-1:0] req_pc,
    input  logic [XLEN-1:0] req_cause,
    output logic            req_ready,
    input  logic            inst_csr_write,
    input  csr_addr_t       inst_csr_raddr,
    input  csr_addr_t       inst_csr_waddr,
    input  logic [XLEN-1:0] inst_csr_wdata,
    output logic [XLEN-1:0] inst_csr_rdata,
    output logic            inst_stall,
    ysyx_25040129_trap_seq_if.master csr,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);
    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] mstatus_new;
    logic [XLEN-1:0] rdata_base;
    logic            upd_is_mret;

    assign upd_is_mret    = (state_q == S_R_STAT);
    assign rdata_base     = {csr.csr_rdata[XLEN-1:2], 2'b00};
    assign inst_csr_rdata = csr.csr_rdata;

    ysyx_25040129_mstatus_upd u_mstatus_upd (
        .old_mstatus (csr.csr_rdata),
        .is_mret     (upd_is_mret),
        .new_mstatus (mstatus_new)
    );

    always_comb begin
        state_d            = state_q;
        pc_d               = pc_q;
        cause_d            = cause_q;
        req_ready          = 1'b0;
        inst_stall         = 1'b1;
        redirect_valid     = 1'b0;
        redirect_pc        = '0;
        csr.csr_write      = 1'b0;
        csr.csr_read_addr  = '0;
        csr.csr_write_addr = '0;
        csr.csr_data       = '0;
        case (state_q)
            S_IDLE: begin
                req_ready          = 1'b1;
                inst_stall         = 1'b0;
                csr.csr_write      = inst_csr_write;
                csr.csr_read_addr  = inst_csr_raddr;
                csr.csr_write_addr = inst_csr_waddr;
                csr.csr_data       = inst_csr_wdata;
                if (req_valid) begin
                    pc_d    = {req_pc[XLEN-1:2], 2'b00};
                    cause_d = req_cause;
                    state_d = req_is_mret ? S_R_STAT : S_T_EPC;
                end
            end
            S_T_EPC: begin
                csr.csr_write      = 1'b1;
                csr.csr_read_addr  = CSR_MEPC;
                csr.csr_write_addr = CSR_MEPC;
                csr.csr_data       = pc_q;
                state_d            = S_T_CAUSE;
            end
            S_T_CAUSE: begin
                csr.csr_write      = 1'b1;
                csr.csr_read_addr  = CSR_MCAUSE;
                csr.csr_write_addr = CSR_MCAUSE;
                csr.csr_data       = cause_q;
                state_d            = S_T_STAT;
            end
            S_T_STAT, S_R_STAT: begin
                csr.csr_write      = 1'b1;
                csr.csr_read_addr  = CSR_MSTATUS;
                csr.csr_write_addr = CSR_MSTATUS;
                csr.csr_data       = mstatus_new;
                state_d            = (state_q == S_T_STAT) ? S_T_VEC : S_R_EPC;
            end
            S_T_VEC: begin
                csr.csr_read_addr = CSR_MTVEC;
                redirect_valid    = 1'b1;
                redirect_pc       = rdata_base;
                // Vectored entry only for interrupts (cause MSB set); sum wraps.
                if (VEC_EN && csr.csr_rdata[1:0] == 2'b01 && cause_q[XLEN-1])
                    redirect_pc = rdata_base + {cause_q[XLEN-3:0], 2'b00};
                state_d = S_IDLE;
            end
            S_R_EPC: begin
                csr.csr_read_addr = CSR_MEPC;
                redirect_valid    = 1'b1;
                redirect_pc       = rdata_base;
                state_d           = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
        end
    end
endmodule
